// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the pipelined array multiplier family.
package mult_pkg;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mult_mode_e;

    function automatic int prod_width(input int w1, input int w2);
        return w1 + w2;
    endfunction

    // Rows folded into each register rank; a zero stage count falls back to a single rank.
    function automatic int rows_per_stage(input int w2, input int stages);
        if (stages < 1) begin
            return w2;
        end
        return (w2 + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/array_mult_row.sv
// One partial-product row: gated a*b[ROW], Baugh-Wooley bit inversion in signed mode,
// folded into the running carry-save pair with a 3:2 compressor.
module array_mult_row
    import mult_pkg::*;
#(
    parameter int INPUT1_WIDTH = 4,
    parameter int INPUT2_WIDTH = 5,
    parameter int ROW          = 0
) (
    input  logic [INPUT1_WIDTH-1:0]              a_i,
    input  logic                                 bBit_i,
    input  mult_mode_e                           mode_i,
    input  logic [INPUT1_WIDTH+INPUT2_WIDTH-1:0] sum_i,
    input  logic [INPUT1_WIDTH+INPUT2_WIDTH-1:0] carry_i,
    output logic [INPUT1_WIDTH+INPUT2_WIDTH-1:0] sum_o,
    output logic [INPUT1_WIDTH+INPUT2_WIDTH-1:0] carry_o
);

    logic [INPUT1_WIDTH+INPUT2_WIDTH-1:0] pp;

    // In signed mode the MSB of ordinary rows and the non-MSB bits of the last row are inverted.
    always_comb begin
        pp = '0;
        for (int i = 0; i < INPUT1_WIDTH; i++) begin
            pp[ROW + i] = (a_i[i] & bBit_i)
                        ^ ((mode_i == MODE_SIGNED) && ((i == INPUT1_WIDTH - 1) != (ROW == INPUT2_WIDTH - 1)));
        end
    end

    assign sum_o   = sum_i ^ carry_i ^ pp;
    assign carry_o = ((sum_i & carry_i) | (sum_i & pp) | (carry_i & pp)) << 1;

endmodule

// File: rtl/pipelined_array_mult.sv
// Pipelined unsigned / two's-complement array multiplier with valid/ready handshake
// and full backpressure; STAGES register ranks of carry-save partial-product rows.
module pipelined_array_mult
    import mult_pkg::*;
#(
    parameter int INPUT1_WIDTH = 4,
    parameter int INPUT2_WIDTH = 5,
    parameter int STAGES       = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [INPUT1_WIDTH-1:0]              a,
    input  logic [INPUT2_WIDTH-1:0]              b,
    input  logic                                 is_signed,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [INPUT1_WIDTH+INPUT2_WIDTH-1:0] product,
    output logic [$clog2(STAGES+1)-1:0]          occupancy
);

    localparam int PW  = prod_width(INPUT1_WIDTH, INPUT2_WIDTH);
    localparam int RPS = rows_per_stage(INPUT2_WIDTH, STAGES);
    localparam int OW  = $clog2(STAGES + 1);

    // Baugh-Wooley constant 2^(W1-1) + 2^(W2-1) + 2^(PW-1), seeded as the initial carry word.
    localparam logic [PW-1:0] ONE        = PW'(1);
    localparam logic [PW-1:0] CORRECTION = (ONE << (INPUT1_WIDTH - 1)) + (ONE << (INPUT2_WIDTH - 1))
                                         + (ONE << (PW - 1));

    if (STAGES < 1 || STAGES > INPUT2_WIDTH) begin : g_badStages
        $fatal(1, "pipelined_array_mult: STAGES must lie in 1..INPUT2_WIDTH");
    end
    if (INPUT1_WIDTH < 2 || INPUT2_WIDTH < 2) begin : g_badWidth
        $fatal(1, "pipelined_array_mult: operand widths must be at least 2");
    end

    typedef struct packed {
        logic                    valid;
        mult_mode_e              mode;
        logic [INPUT1_WIDTH-1:0] a;
        logic [INPUT2_WIDTH-1:0] b;
        logic [PW-1:0]           sum;
        logic [PW-1:0]           carry;
    } rank_t;

    rank_t         stageIn [STAGES];
    rank_t         rank_d  [STAGES];
    rank_t         rank_q  [STAGES];
    logic [PW-1:0] rowSumIn    [INPUT2_WIDTH];
    logic [PW-1:0] rowCarryIn  [INPUT2_WIDTH];
    logic [PW-1:0] rowSumOut   [INPUT2_WIDTH];
    logic [PW-1:0] rowCarryOut [INPUT2_WIDTH];
    logic [OW-1:0] occupancy_d, occupancy_q;
    logic          advance, accept, handoff;

    assign advance   = !rank_q[STAGES-1].valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = rank_q[STAGES-1].valid;
    assign accept    = in_valid && advance;
    assign handoff   = out_valid && out_ready;
    assign product   = rank_q[STAGES-1].sum + rank_q[STAGES-1].carry;
    assign occupancy = occupancy_q;

    assign stageIn[0] = '{valid: in_valid, mode: mult_mode_e'(is_signed), a: a, b: b,
                          sum: '0, carry: (is_signed ? CORRECTION : '0)};

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign stageIn[k] = rank_q[k-1];
    end

    // Ranks past the last row (possible when rows do not divide evenly) just forward their input.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int FIRST = k * RPS;
        localparam int LAST  = (((k + 1) * RPS < INPUT2_WIDTH) ? (k + 1) * RPS : INPUT2_WIDTH) - 1;
        if (FIRST < INPUT2_WIDTH) begin : g_rows
            assign rank_d[k] = '{valid: stageIn[k].valid, mode: stageIn[k].mode,
                                 a: stageIn[k].a, b: stageIn[k].b,
                                 sum: rowSumOut[LAST], carry: rowCarryOut[LAST]};
        end else begin : g_pass
            assign rank_d[k] = stageIn[k];
        end
    end

    for (genvar j = 0; j < INPUT2_WIDTH; j++) begin : g_row
        localparam int K = j / RPS;
        if (j % RPS == 0) begin : g_first
            assign rowSumIn[j]   = stageIn[K].sum;
            assign rowCarryIn[j] = stageIn[K].carry;
        end else begin : g_chain
            assign rowSumIn[j]   = rowSumOut[j-1];
            assign rowCarryIn[j] = rowCarryOut[j-1];
        end
        array_mult_row #(
            .INPUT1_WIDTH(INPUT1_WIDTH),
            .INPUT2_WIDTH(INPUT2_WIDTH),
            .ROW         (j)
        ) u_row (
            .a_i    (stageIn[K].a),
            .bBit_i (stageIn[K].b[j]),
            .mode_i (stageIn[K].mode),
            .sum_i  (rowSumIn[j]),
            .carry_i(rowCarryIn[j]),
            .sum_o  (rowSumOut[j]),
            .carry_o(rowCarryOut[j])
        );
    end

    always_comb begin
        occupancy_d = occupancy_q + OW'(accept) - OW'(handoff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                rank_q[k] <= '0;
            end
            occupancy_q <= '0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                rank_q[k] <= rank_d[k];
            end
            occupancy_q <= occupancy_d;
        end
    end

endmodule

// File: tb/tb_pipelined_array_mult.sv
// Self-checking bench: stall-aware delay-line model with arithmetic reference products,
// plus hand-computed directed vectors for the default 4x5, two-rank configuration.
module tb_pipelined_array_mult;

    localparam int W1 = 4;
    localparam int W2 = 5;
    localparam int S  = 2;
    localparam int P  = W1 + W2;
    localparam int OW = $clog2(S + 1);

    logic          clk = 1'b0;
    logic          rstN;
    logic          inValid;
    logic          inReady;
    logic [W1-1:0] aIn;
    logic [W2-1:0] bIn;
    logic          sIn;
    logic          outValid;
    logic          outReady;
    logic [P-1:0]  product;
    logic [OW-1:0] occupancy;

    int            checks = 0;
    int            errors = 0;
    int            handCnt = 0;
    logic          mv [S];
    logic [P-1:0]  mp [S];
    logic [P-1:0]  gotQ [$];

    always #5 clk = ~clk;

    pipelined_array_mult #(
        .INPUT1_WIDTH(W1),
        .INPUT2_WIDTH(W2),
        .STAGES      (S)
    ) dut (
        .clk      (clk),
        .rst_n    (rstN),
        .in_valid (inValid),
        .in_ready (inReady),
        .a        (aIn),
        .b        (bIn),
        .is_signed(sIn),
        .out_valid(outValid),
        .out_ready(outReady),
        .product  (product),
        .occupancy(occupancy)
    );

    function automatic logic [P-1:0] refProd(input logic [W1-1:0] a, input logic [W2-1:0] b, input logic s);
        longint x;
        longint y;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        return P'(x * y);
    endfunction

    function automatic int modelOcc();
        int n = 0;
        for (int i = 0; i < S; i++) begin
            if (mv[i]) n++;
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference pipe: S slots that shift whenever the output is empty or being taken.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < S; i++) begin
                mv[i] = 1'b0;
                mp[i] = '0;
            end
        end else if (!mv[S-1] || outReady) begin
            for (int i = S - 1; i > 0; i--) begin
                mv[i] = mv[i-1];
                mp[i] = mp[i-1];
            end
            mv[0] = inValid;
            mp[0] = refProd(aIn, bIn, sIn);
        end
    end

    always @(negedge clk) begin
        if (rstN === 1'b1) begin
            checkOutput("out_valid", outValid, mv[S-1]);
            checkOutput("in_ready", inReady, !mv[S-1] || outReady);
            checkOutput("occupancy", occupancy, modelOcc());
            if (mv[S-1]) checkOutput("product", product, mp[S-1]);
            if (outValid && outReady) begin
                gotQ.push_back(product);
                handCnt++;
            end
        end
    end

    task automatic applyStimulus(input logic [W1-1:0] a, input logic [W2-1:0] b, input logic s, input bit randReady);
        bit taken = 1'b0;
        int guard = 0;
        aIn = a;
        bIn = b;
        sIn = s;
        inValid = 1'b1;
        while (!taken && guard < 200) begin
            if (randReady) outReady = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            taken = inReady;
            @(posedge clk);
            #1;
            guard++;
        end
        inValid = 1'b0;
        if (!taken) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no accept, expected accept within 200 cycles");
        end
    endtask

    task automatic directedCheck(input string name, input logic [W1-1:0] a, input logic [W2-1:0] b,
                                 input logic s, input logic [P-1:0] expected);
        outReady = 1'b1;
        applyStimulus(a, b, s, 1'b0);
        checkOutput({name, "_early"}, outValid, 0);
        @(posedge clk);
        #1;
        checkOutput({name, "_valid"}, outValid, 1);
        checkOutput(name, product, expected);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish within 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [P-1:0] stallExp [3];
        logic [W1-1:0] va;
        logic [W2-1:0] vb;
        time t0;
        int g;

        rstN = 1'b0;
        inValid = 1'b0;
        outReady = 1'b1;
        aIn = '0;
        bIn = '0;
        sIn = 1'b0;
        #1;
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_occupancy", occupancy, 0);
        checkOutput("rst_in_ready", inReady, 1);
        checkOutput("rst_product", product, 0);
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;

        directedCheck("u15x31", 4'd15, 5'd31, 1'b0, 9'd465);
        directedCheck("s_min_min", 4'b1000, 5'b10000, 1'b1, 9'd128);
        directedCheck("s7xm16", 4'd7, 5'b10000, 1'b1, 9'h190);
        directedCheck("sm1xm1", 4'hF, 5'h1F, 1'b1, 9'd1);
        directedCheck("u0x31", 4'd0, 5'd31, 1'b0, 9'd0);
        directedCheck("s_m8x15", 4'b1000, 5'd15, 1'b1, 9'h188);

        gotQ.delete();
        outReady = 1'b1;
        t0 = $time;
        for (int i = 0; i < 20; i++) begin
            va = W1'(i * 3 + 1);
            vb = W2'(i * 7 + 2);
            applyStimulus(va, vb, i[0], 1'b0);
        end
        checkOutput("b2b_cycles", 32'(($time - t0) / 10), 20);
        repeat (S) @(posedge clk);
        #1;
        checkOutput("b2b_count", gotQ.size(), 20);
        for (int i = 0; i < 20; i++) begin
            va = W1'(i * 3 + 1);
            vb = W2'(i * 7 + 2);
            checkOutput("b2b_order", (i < gotQ.size()) ? 32'(gotQ[i]) : 32'hDEAD_BEEF, 32'(refProd(va, vb, i[0])));
        end

        gotQ.delete();
        outReady = 1'b0;
        applyStimulus(4'd3, 5'd5, 1'b0, 1'b0);
        applyStimulus(4'd2, 5'd7, 1'b0, 1'b0);
        aIn = 4'hE;
        bIn = 5'd3;
        sIn = 1'b1;
        inValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", inReady, 0);
            checkOutput("stall_out_valid", outValid, 1);
            checkOutput("stall_product", product, 15);
            checkOutput("stall_occupancy", occupancy, S);
            @(posedge clk);
            #1;
        end
        outReady = 1'b1;
        applyStimulus(4'hE, 5'd3, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        stallExp[0] = 9'd15;
        stallExp[1] = 9'd14;
        stallExp[2] = 9'h1FA;
        checkOutput("stall_count", gotQ.size(), 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_order", (i < gotQ.size()) ? 32'(gotQ[i]) : 32'hDEAD_BEEF, 32'(stallExp[i]));
        end

        outReady = 1'b1;
        applyStimulus(4'd5, 5'd6, 1'b0, 1'b0);
        applyStimulus(4'd9, 5'd9, 1'b0, 1'b0);
        checkOutput("pre_rst_occupancy", occupancy, 2);
        rstN = 1'b0;
        #1;
        checkOutput("midrst_out_valid", outValid, 0);
        checkOutput("midrst_occupancy", occupancy, 0);
        checkOutput("midrst_in_ready", inReady, 1);
        checkOutput("midrst_product", product, 0);
        gotQ.delete();
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("post_rst_emitted", gotQ.size(), 0);

        handCnt = 0;
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 32; b++) begin
                    applyStimulus(W1'(a), W2'(b), s[0], 1'b1);
                end
            end
        end
        outReady = 1'b1;
        g = 0;
        while (modelOcc() > 0 && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        @(posedge clk);
        #1;
        checkOutput("exh_handoffs", handCnt, 1024);
        checkOutput("exh_drained", occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
